// File: rtl/tone_clock_divider.sv
// Square-wave tone generator: fixed prescaler tick plus
// programmable half-period divider driving a differential buzzer.
module tone_clock_divider #(
  parameter int PRESCALE_DIV = 50,
  parameter int COUNT_W      = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [COUNT_W-1:0] count_i,
  output logic               tick_o,
  output logic               freq_o,
  output logic               freq_n_o
);

  localparam int PW =
    (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(PRESCALE_DIV - 1);

  logic [PW-1:0]      pre_d;
  logic [PW-1:0]      pre_q;
  logic [COUNT_W-1:0] cnt_d;
  logic [COUNT_W-1:0] cnt_q;
  logic               freq_d;
  logic               freq_q;
  logic               tick;

  // tick is decoded from the prescale register, never from inputs
  assign tick = (pre_q == PRE_LAST);

  // free-running prescaler, wraps to zero on the tick
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (tick) begin
      pre_d = '0;
    end
  end

  // divider: clear when disabled, toggle at terminal count on a tick
  always_comb begin
    cnt_d  = cnt_q;
    freq_d = freq_q;
    if (!en_i) begin
      cnt_d  = '0;
      freq_d = 1'b0;
    end else if (tick) begin
      if (cnt_q >= count_i) begin
        cnt_d  = '0;
        freq_d = ~freq_q;
      end else begin
        cnt_d = cnt_q + COUNT_W'(1);
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      freq_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      freq_q <= freq_d;
    end
  end

  assign tick_o   = tick;
  assign freq_o   = freq_q;
  assign freq_n_o = ~freq_q;

endmodule

// File: tb/tb_tone_clock_divider.sv
// Self-checking bench: vector table, directed corner cases and
// randomized stimulus against an arithmetic reference model.
module tb_tone_clock_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] cnt;
  logic        tick_o, freq_o, freq_n_o;
  logic        en1;
  logic [7:0]  cnt1;
  logic        tick1, freq1, freq1_n;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int n0 = 0, k0 = 0, n1 = 0, k1 = 0;
  bit f0 = 0, f1 = 0;
  int last1 = -1;
  bit prev1 = 0;

  always #5 clk = ~clk;

  tone_clock_divider #(.PRESCALE_DIV(4), .COUNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .count_i(cnt),
    .tick_o(tick_o), .freq_o(freq_o), .freq_n_o(freq_n_o)
  );

  tone_clock_divider #(.PRESCALE_DIV(1), .COUNT_W(8)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en1), .count_i(cnt1),
    .tick_o(tick1), .freq_o(freq1), .freq_n_o(freq1_n)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d",
               nm, cyc, act, exp);
    end
  endtask

  // n = edges since reset release, k = ticks into half period
  task automatic mstep(input int p, input bit r, input bit e,
                       input int c, inout int n, inout int k,
                       inout bit f);
    bit t;
    if (r) begin
      n = 0; k = 0; f = 0;
    end else begin
      t = ((n % p) == p - 1);
      n++;
      if (!e) begin
        k = 0; f = 0;
      end else if (t) begin
        if (k >= c) begin
          k = 0; f = !f;
        end else begin
          k++;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    mstep(4, rst, en, int'(cnt), n0, k0, f0);
    mstep(1, rst, en1, int'(cnt1), n1, k1, f1);
    @(negedge clk);
    cyc++;
    chk("m_tick", int'(tick_o), int'((n0 % 4) == 3));
    chk("m_freq", int'(freq_o), int'(f0));
    chk("m_freq_n", int'(freq_n_o), int'(!f0));
    chk("m1_tick", int'(tick1), 1);
    chk("m1_freq", int'(freq1), int'(f1));
    chk("m1_freq_n", int'(freq1_n), int'(!f1));
    if (rst) begin
      last1 = -1;
    end else if (freq1 !== prev1) begin
      if (last1 >= 0) chk("x_interval", cyc - last1, 256);
      last1 = cyc;
    end
    prev1 = freq1;
  endtask

  typedef struct {
    bit rst; bit en; int cnt; bit tk; bit fq;
  } vec_t;

  vec_t tbl[15];
  int   q[$];
  int   ticks, cnt_tk, last_tk;
  bit   pf, t, done;

  initial begin
    rst = 1; en = 1; cnt = 16'd5; en1 = 1; cnt1 = 8'hFF;

    tbl[0]  = '{1, 1, 5, 0, 0};
    tbl[1]  = '{1, 1, 5, 0, 0};
    tbl[2]  = '{1, 1, 5, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 0};
    tbl[5]  = '{0, 1, 0, 1, 0};
    tbl[6]  = '{0, 1, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 1, 1};
    tbl[10] = '{0, 1, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0};
    tbl[12] = '{0, 1, 0, 0, 0};
    tbl[13] = '{0, 1, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 0, 1};

    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].rst; en = tbl[i].en;
      cnt = 16'(tbl[i].cnt);
      step();
      chk($sformatf("vec%0d_tick", i), int'(tick_o),
          int'(tbl[i].tk));
      chk($sformatf("vec%0d_freq", i), int'(freq_o),
          int'(tbl[i].fq));
    end

    // prescaler over 40 cycles with en toggling
    cnt_tk = 0; last_tk = -1;
    for (int i = 0; i < 40; i++) begin
      en = $urandom_range(0, 1);
      step();
      if (tick_o === 1'b1) begin
        if (last_tk >= 0) chk("tick_space", cyc - last_tk, 4);
        last_tk = cyc;
        cnt_tk++;
      end
    end
    chk("tick_count", cnt_tk, 10);

    // divide ratios: count 2 -> half 12, count 0 -> half 4
    for (int m = 0; m < 2; m++) begin
      en = 1; cnt = (m == 0) ? 16'd2 : 16'd0;
      q.delete();
      pf = freq_o;
      for (int i = 0; i < 100; i++) begin
        step();
        if (freq_o !== pf) q.push_back(cyc);
        pf = freq_o;
      end
      chk("div_toggles", int'(q.size() >= 4), 1);
      if (q.size() >= 4) begin
        chk("div_half", q[2] - q[1], (m == 0) ? 12 : 4);
        chk("div_period", q[3] - q[1], (m == 0) ? 24 : 8);
      end
    end

    // disable while high, then re-enable with count 1
    en = 1; cnt = 16'd1; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      step();
      done = (freq_o === 1'b1);
    end
    chk("dis_wait_high", int'(done), 1);
    en = 0;
    step();
    chk("dis_freq", int'(freq_o), 0);
    chk("dis_freq_n", int'(freq_n_o), 1);
    en = 1; cnt = 16'd1; ticks = 0; done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      t = tick_o;
      step();
      if (t) ticks++;
      done = (freq_o === 1'b1);
    end
    chk("reen_rise_seen", int'(done), 1);
    chk("reen_ticks", ticks, 2);

    // live count change from 100 to 10 with tick counter at 50
    en = 0;
    step();
    en = 1; cnt = 16'd100; done = 0;
    for (int i = 0; i < 1000 && !done; i++) begin
      step();
      done = (k0 == 50);
    end
    chk("live_reach50", int'(done), 1);
    cnt = 16'd10;
    for (int h = 0; h < 2; h++) begin
      ticks = 0; done = 0; pf = freq_o;
      for (int i = 0; i < 200 && !done; i++) begin
        t = tick_o;
        step();
        if (t) ticks++;
        done = (freq_o !== pf);
      end
      chk("live_toggle_seen", int'(done), 1);
      chk("live_ticks", ticks, (h == 0) ? 1 : 11);
    end

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 7) != 0);
      cnt = 16'($urandom_range(0, 5));
      if ($urandom_range(0, 49) == 0) cnt = 16'($urandom);
      step();
    end
    rst = 0; en = 1;
    for (int i = 0; i < 600; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
